// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller.
// Blocking refill of one full line per miss, in word order.
module icache_ctrl #(
  parameter int N_LINES            = 8,
  parameter int N_CACHELINE_LENGTH = 4,
  parameter int BITSIZE            = 32
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               req_i,
  input  logic [BITSIZE-1:0] addr_i,
  output logic               ack_o,
  output logic [BITSIZE-1:0] data_o,
  output logic               miss_o,
  output logic               mem_req_o,
  output logic [BITSIZE-1:0] mem_addr_o,
  input  logic               mem_valid_i,
  input  logic [BITSIZE-1:0] mem_data_i
);

  localparam int OW = $clog2(N_CACHELINE_LENGTH);
  localparam int IW = $clog2(N_LINES);
  localparam int TW = BITSIZE - OW - IW;
  localparam int NW = N_LINES * N_CACHELINE_LENGTH;
  localparam logic [OW-1:0] LAST = OW'(N_CACHELINE_LENGTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic [TW-1:0]      tag_mem  [N_LINES];
  logic [BITSIZE-1:0] data_mem [NW];
  logic [N_LINES-1:0] valid_q;
  logic [BITSIZE-1:0] lat_q;
  logic [OW-1:0]      cnt_q;
  logic               pend_q;
  logic [BITSIZE-1:0] data_q;

  logic [OW-1:0] off, lat_off;
  logic [IW-1:0] idx, lat_idx;
  logic [TW-1:0] tag, lat_tag;

  assign off     = addr_i[OW-1:0];
  assign idx     = addr_i[OW+IW-1:OW];
  assign tag     = addr_i[BITSIZE-1:OW+IW];
  assign lat_off = lat_q[OW-1:0];
  assign lat_idx = lat_q[OW+IW-1:OW];
  assign lat_tag = lat_q[BITSIZE-1:OW+IW];

  logic hit, blocked, take, refill_wr, last_word;

  // A pending or live flush owns the IDLE cycle; the request waits.
  assign hit       = valid_q[idx] && (tag_mem[idx] == tag);
  assign blocked   = flush_i || pend_q;
  assign take      = (state_q == IDLE) && req_i && !blocked && !rst_i;
  assign refill_wr = !rst_i && (state_q == REFILL) && mem_valid_i;
  assign last_word = refill_wr && (cnt_q == LAST);

  assign ack_o      = (state_q == RESP);
  assign mem_req_o  = (state_q == REFILL);
  assign miss_o     = take && !hit;
  assign mem_addr_o = {lat_q[BITSIZE-1:OW], cnt_q};
  assign data_o     = data_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (take) state_d = hit ? RESP : REFILL;
      end
      REFILL: begin
        if (mem_valid_i && (cnt_q == LAST)) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= IDLE;
      valid_q <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (blocked) begin
            valid_q <= '0;
            pend_q  <= 1'b0;
          end else if (req_i) begin
            if (hit) begin
              data_q <= data_mem[{idx, off}];
            end else begin
              cnt_q        <= '0;
              valid_q[idx] <= 1'b0;
            end
          end
        end
        REFILL: begin
          if (flush_i) pend_q <= 1'b1;
          if (mem_valid_i) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
              valid_q[lat_idx] <= 1'b1;
              data_q <= (lat_off == LAST) ? mem_data_i
                                          : data_mem[{lat_idx, lat_off}];
            end
          end
        end
        RESP: begin
          if (flush_i) pend_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Storage arrays and the latched miss address carry no reset.
  always_ff @(posedge clk) begin
    if (take && !hit) lat_q <= addr_i;
    if (last_word) tag_mem[lat_idx] <= lat_tag;
    if (refill_wr) data_mem[{lat_idx, cnt_q}] <= mem_data_i;
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Scoreboard bench for icache_ctrl with a line-level cache model
// and a memory responder deriving word values from the address.
module tb_icache_ctrl;

  localparam int NL = 8;
  localparam int CL = 4;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        req_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic        ack_o;
  logic [31:0] data_o;
  logic        miss_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_valid_i = 1'b0;
  logic [31:0] mem_data_i = '0;

  always #5 clk = ~clk;

  icache_ctrl #(
    .N_LINES(NL),
    .N_CACHELINE_LENGTH(CL),
    .BITSIZE(32)
  ) dut (
    .clk(clk),
    .rst_i(rst_i),
    .flush_i(flush_i),
    .req_i(req_i),
    .addr_i(addr_i),
    .ack_o(ack_o),
    .data_o(data_o),
    .miss_o(miss_o),
    .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o),
    .mem_valid_i(mem_valid_i),
    .mem_data_i(mem_data_i)
  );

  typedef struct {
    logic [31:0] data;
    bit          miss;
    bit          blk;
    int          issue;
  } exp_t;

  exp_t sb[$];

  int vectors = 0;
  int errors = 0;
  int cyc_cnt = 0;

  // line-level model: which tag each index holds, if any
  bit mv[NL];
  int mt[NL];
  bit pend = 0;

  int          k = 0;
  int          stop_at = CL;
  int          mode = 0;
  int          gap = 0;
  int          last_valid_cyc = 0;
  bit          refill_exp = 0;
  logic [31:0] base = '0;
  bit          miss_seen = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a + 32'h90;
  endfunction

  function automatic void check(input string name,
                                input logic [31:0] act,
                                input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void model_flush();
    for (int i = 0; i < NL; i++) mv[i] = 0;
    pend = 0;
  endfunction

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // memory responder
  initial begin
    bit v;
    forever begin
      @(negedge clk);
      mem_valid_i = 1'b0;
      mem_data_i  = $urandom;
      if (!rst_i) begin
        if (mem_req_o) begin
          if (!refill_exp) begin
            check("mem_req_unexpected", {31'b0, mem_req_o}, 32'd0);
          end else begin
            check("mem_addr", mem_addr_o, base + k);
            if (k < stop_at) begin
              case (mode)
                0: v = 1'b1;
                1: v = 1'($urandom_range(0, 1));
                default: begin
                  v = (gap == 3);
                  gap = v ? 0 : gap + 1;
                end
              endcase
              if (v) begin
                mem_valid_i = 1'b1;
                mem_data_i  = memf(base + k);
                k++;
                if (k == CL) begin
                  refill_exp = 0;
                  last_valid_cyc = cyc_cnt;
                end
              end
            end
          end
        end else if ($urandom_range(0, 3) == 0) begin
          mem_valid_i = 1'b1;
        end
      end
    end
  end

  // response monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_i && miss_o) begin
        if (sb.size() == 0) begin
          check("miss_spurious", {31'b0, miss_o}, 32'd0);
        end else begin
          check("miss_expected", {31'b0, miss_o}, {31'b0, sb[0].miss});
          check("miss_cycle", cyc_cnt, sb[0].issue + int'(sb[0].blk));
          miss_seen = 1;
        end
      end
      if (!rst_i && ack_o) begin
        if (sb.size() == 0) begin
          check("ack_spurious", {31'b0, ack_o}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("data", data_o, e.data);
          check("miss_flag", {31'b0, miss_seen}, {31'b0, e.miss});
          if (e.miss)
            check("miss_ack_cycle", cyc_cnt, last_valid_cyc + 1);
          else
            check("hit_ack_cycle", cyc_cnt, e.issue + 1 + int'(e.blk));
          miss_seen = 0;
        end
      end
    end
  end

  // entered #1 after a rising edge; leaves #1 after the edge ending RESP
  task automatic issue(input logic [31:0] a, input bit fl_req,
                       input bit fl_mid);
    exp_t e;
    int   idx, tg;
    bit   done;
    e.blk = fl_req || pend;
    if (e.blk) model_flush();
    idx = int'((a >> 2) & 32'd7);
    tg  = int'(a >> 5);
    e.miss  = !(mv[idx] && mt[idx] == tg);
    e.data  = memf(a);
    e.issue = cyc_cnt;
    if (e.miss) begin
      mv[idx] = 0;
      base = a & ~32'd3;
      k = 0;
      gap = 0;
      refill_exp = 1;
    end
    sb.push_back(e);
    req_i   = 1'b1;
    addr_i  = a;
    flush_i = fl_req;
    done = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (ack_o) begin
        done = 1;
        break;
      end
      @(posedge clk);
      #1;
      flush_i = fl_mid && e.miss && (n == 2);
    end
    if (!done) begin
      vectors++;
      errors++;
      $display("FAIL ack_timeout: addr %0h got no ack within 300 cycles", a);
      sb.delete();
      refill_exp = 0;
    end
    if (e.miss) begin
      mv[idx] = 1;
      mt[idx] = tg;
    end
    if (fl_mid && e.miss) pend = 1;
    @(posedge clk);
    #1;
    req_i   = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic idle_flush();
    req_i   = 1'b0;
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    model_flush();
  endtask

  task automatic reset_mid(input logic [31:0] a);
    exp_t e;
    bit   ok;
    e.blk = pend;
    if (e.blk) model_flush();
    e.miss  = 1;
    e.data  = memf(a);
    e.issue = cyc_cnt;
    sb.push_back(e);
    base = a & ~32'd3;
    k = 0;
    stop_at = 2;
    mode = 0;
    refill_exp = 1;
    req_i  = 1'b1;
    addr_i = a;
    ok = 0;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk);
      #1;
      if (k >= 2) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      vectors++;
      errors++;
      $display("FAIL reset_mid_timeout: words %0d required 2", k);
    end
    rst_i = 1'b1;
    req_i = 1'b0;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    refill_exp = 0;
    stop_at = CL;
    if (sb.size() != 0) void'(sb.pop_front());
    miss_seen = 0;
    model_flush();
    @(negedge clk);
    check("rst_mid_mem_req", {31'b0, mem_req_o}, 32'd0);
    check("rst_mid_ack", {31'b0, ack_o}, 32'd0);
    check("rst_mid_data", data_o, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("reset_ack", {31'b0, ack_o}, 32'd0);
    check("reset_miss", {31'b0, miss_o}, 32'd0);
    check("reset_mem_req", {31'b0, mem_req_o}, 32'd0);
    check("reset_data", data_o, 32'd0);
    @(posedge clk);
    #1;

    issue(32'h13, 0, 0);
    issue(32'h11, 0, 0);
    issue(32'h33, 0, 0);
    issue(32'h13, 0, 0);
    mode = 2;
    issue(32'h15, 0, 0);
    mode = 0;
    issue(32'h20, 0, 1);
    issue(32'h20, 0, 0);
    issue(32'h21, 0, 0);
    issue(32'h13, 1, 0);
    reset_mid(32'h44);
    issue(32'h44, 0, 0);
    issue(32'h46, 0, 0);

    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 99);
      if (r < 5) idle_flush();
      mode = $urandom_range(0, 2);
      issue($urandom_range(0, 127), r >= 5 && r < 12, r >= 12 && r < 20);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 SHALL have parameter N_LINES, default 8, number of direct-mapped lines (power of two).
REQ-002 SHALL have parameter N_CACHELINE_LENGTH, default 4, words per line (power of two).
REQ-003 SHALL have parameter BITSIZE, default 32, word and address width.
REQ-004 SHALL have port clk  input  1  clock; only clock, all state on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port flush_i  input  1  invalidate all lines.
REQ-007 SHALL have port req_i  input  1  requester read request; held until ack_o.
REQ-008 SHALL have port addr_i  input  BITSIZE  word address; stable while req_i high.
REQ-009 SHALL have port ack_o  output  1  one-cycle response strobe.
REQ-010 SHALL have port data_o  output  BITSIZE  read data, valid when ack_o=1.
REQ-011 SHALL have port miss_o  output  1  one-cycle pulse on detected miss.
REQ-012 SHALL have port mem_req_o  output  1  refill request to memory.
REQ-013 SHALL have port mem_addr_o  output  BITSIZE  word address of the refill word currently requested.
REQ-014 SHALL have port mem_valid_i  input  1  memory returns one word this cycle.
REQ-015 SHALL have port mem_data_i  input  BITSIZE  returned word.

Function
REQ-016 SHALL split addr_i as offset = low OW=log2(N_CACHELINE_LENGTH) bits, index = next IW=log2(N_LINES) bits, tag = remaining upper bits.
REQ-017 SHALL keep per line: valid bit, tag, N_CACHELINE_LENGTH data words.
REQ-018 SHALL implement FSM states IDLE, REFILL, RESP.
REQ-019 IDLE: req_i=1 and flush_i=0 and hit (valid[index] and stored tag==tag) -> RESP next cycle, data_o registered from line[index][offset].
REQ-020 IDLE: req_i=1 and flush_i=0 and miss -> REFILL next cycle; latch addr_i; word counter=0; miss_o=1 in that same cycle.
REQ-021 REFILL: mem_req_o=1 throughout; mem_addr_o = {latched tag, latched index, counter}; words fetched in order 0..N_CACHELINE_LENGTH-1.
REQ-022 REFILL: each cycle with mem_valid_i=1 writes mem_data_i into line word [counter], counter increments (modulo N_CACHELINE_LENGTH); mem_valid_i=0 stalls with no change.
REQ-023 REFILL: mem_valid_i=1 with counter=N_CACHELINE_LENGTH-1 -> write tag, set valid bit, register data_o from latched offset word (taking mem_data_i if offset is last), go RESP.
REQ-024 Line valid bit SHALL stay 0 for the refilled index from REFILL entry until completion (old contents not hit during refill).
REQ-025 RESP: ack_o=1 for exactly one cycle, then IDLE unconditionally; req_i not sampled in RESP.
REQ-026 ack_o, mem_req_o SHALL be decoded from state only; data_o holds last value outside RESP.
REQ-027 Hit latency: req_i sampled cycle t -> ack_o in t+1; next request sampled earliest t+2.
REQ-028 Miss latency: ack_o one cycle after the cycle carrying the final mem_valid_i.
REQ-029 mem_valid_i outside REFILL SHALL be ignored.
REQ-030 flush_i in IDLE SHALL clear all valid bits at next edge and take priority over req_i (request not sampled that cycle).
REQ-031 flush_i in REFILL or RESP SHALL set a pending flag; the in-flight refill completes and acks normally; pending flush applied on first IDLE cycle, blocking req_i that cycle, flag then cleared.

Reset
REQ-032 rst_i=1 SHALL force next edge: state IDLE, all valid bits 0, counter 0, pending flush 0, data_o 0; outputs ack_o=0, miss_o=0, mem_req_o=0.
REQ-033 rst_i during REFILL SHALL abort refill; no line validated; mem_req_o=0 from next cycle.
REQ-034 Tag and data arrays SHALL need no reset.

Verification
REQ-035 Cold miss: reset, req_i addr 0x00000013 -> miss_o pulse, mem_addr_o 0x10,0x11,0x12,0x13 with memory returning 0xA0..0xA3 -> ack_o one cycle, data_o=0xA3.
REQ-036 Hit after fill: req addr 0x00000011 -> ack_o exactly 1 cycle after req, data_o=0xA1, mem_req_o stays 0.
REQ-037 Conflict: addr 0x00000033 (same index, new tag) -> miss, refill from 0x30; then 0x13 misses again.
REQ-038 Stalled memory: mem_valid_i gaps of 3 cycles between words -> mem_addr_o holds, counter not advanced, correct data ack'd.
REQ-039 Flush: flush_i during refill of 0x20 -> refill acks; next req 0x20 one cycle after return to IDLE blocked, then misses.
REQ-040 Reset mid-refill after 2 words -> IDLE, mem_req_o=0, subsequent req same address misses.
